// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM and its clear sequencer.
package ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 2;
    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every word once after reset or on request, holding off user traffic meanwhile.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          clrReq,
    output logic          initBusy,
    output logic [AW-1:0] clrAdress,
    output logic          clrWe
);

    localparam logic [AW-1:0] LAST_C = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_C  = AW'(1);
    localparam logic [AW-1:0] ZERO_C = AW'(0);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Next-state logic: INIT counts to the last word, RUN waits for a clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_C) begin
                    state_d = ST_RUN;
                    cnt_d   = ZERO_C;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            ST_RUN: begin
                if (clrReq) begin
                    state_d = ST_INIT;
                    cnt_d   = ZERO_C;
                end else begin
                    cnt_d = ZERO_C;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = ZERO_C;
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    // State, counter and busy flag registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_INIT;
            cnt_q   <= ZERO_C;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign initBusy  = busy_q;
    assign clrWe     = busy_q;
    assign clrAdress = cnt_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte-enabled writes, 1- or 2-cycle reads, defined
// read-during-write behaviour and a hardware clear to INIT_VAL.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 16,
    parameter int               RD_LAT   = 1,
    parameter int               RDW_MODE = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}},
    localparam int              BE_W     = WIDTH / 8,
    localparam int              AW       = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clrReq,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAdress,
    input  logic [WIDTH-1:0] wrData,
    input  logic [BE_W-1:0]  wrBe,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAdress,
    output logic [WIDTH-1:0] rdData,
    output logic             rdValid,
    output logic             initBusy
);

    if ((WIDTH < 8) || ((WIDTH % 8) != 0)) begin : g_bad_width
        $error("ram_dp_be: WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("ram_dp_be: DEPTH must be at least 1");
    end
    if ((RD_LAT != RD_LAT_MIN) && (RD_LAT != RD_LAT_MAX)) begin : g_bad_lat
        $error("ram_dp_be: RD_LAT must be 1 or 2");
    end
    if ((RDW_MODE != RDW_OLD_DATA) && (RDW_MODE != RDW_NEW_DATA)) begin : g_bad_rdw
        $error("ram_dp_be: RDW_MODE must be 0 or 1");
    end

    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic        RDW_NEW_C = (RDW_MODE == RDW_NEW_DATA);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             init_busy_s, clr_we_s;
    logic [AW-1:0]    clr_addr_s;
    logic             wr_ok_s, rd_ok_s, rd_in_range_s, rdw_hit_s;
    logic [WIDTH-1:0] rd_old_s, rd_merge_s, rd_word_s;
    logic             out_vld_s;
    logic [WIDTH-1:0] out_data_s;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;

    ram_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clk       (clk),
        .rstN      (rstN),
        .clrReq    (clrReq),
        .initBusy  (init_busy_s),
        .clrAdress (clr_addr_s),
        .clrWe     (clr_we_s)
    );

    assign wr_ok_s       = wrEn & ~init_busy_s & ({1'b0, wrAdress} < DEPTH_C);
    assign rd_ok_s       = rdEn & ~init_busy_s;
    assign rd_in_range_s = ({1'b0, rdAdress} < DEPTH_C);
    assign rdw_hit_s     = RDW_NEW_C & wr_ok_s & (wrAdress == rdAdress);

    // Storage array: clear sequencer owns the write port while busy; no reset on the array.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[clr_addr_s] <= INIT_VAL;
        end else if (wr_ok_s) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wrBe[k]) begin
                    mem_q[wrAdress][8*k +: 8] <= wrData[8*k +: 8];
                end
            end
        end
    end

    // Read word selection, including same-cycle write forwarding in new-data mode.
    always_comb begin
        rd_old_s   = mem_q[rdAdress];
        rd_merge_s = rd_old_s;
        for (int k = 0; k < BE_W; k++) begin
            rd_merge_s[8*k +: 8] = wrBe[k] ? wrData[8*k +: 8] : rd_old_s[8*k +: 8];
        end
        if (!rd_in_range_s) begin
            rd_word_s = {WIDTH{1'b0}};
        end else if (rdw_hit_s) begin
            rd_word_s = rd_merge_s;
        end else begin
            rd_word_s = rd_old_s;
        end
    end

    if (RD_LAT == RD_LAT_MAX) begin : g_lat2
        logic             s1_vld_q;
        logic [WIDTH-1:0] s1_data_q;

        // Extra pipeline stage for the two-cycle read.
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                s1_vld_q  <= 1'b0;
                s1_data_q <= {WIDTH{1'b0}};
            end else begin
                s1_vld_q <= rd_ok_s;
                if (rd_ok_s) begin
                    s1_data_q <= rd_word_s;
                end
            end
        end

        assign out_vld_s  = s1_vld_q;
        assign out_data_s = s1_data_q;
    end else begin : g_lat1
        assign out_vld_s  = rd_ok_s;
        assign out_data_s = rd_word_s;
    end

    // Output register: data holds its last value when no read completes.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= {WIDTH{1'b0}};
        end else begin
            rd_valid_q <= out_vld_s;
            if (out_vld_s) begin
                rd_data_q <= out_data_s;
            end
        end
    end

    assign rdValid  = rd_valid_q;
    assign rdData   = rd_data_q;
    assign initBusy = init_busy_s;

endmodule
